// File: rtl/dsm_pkg.sv
// Shared types and helpers for the delta-sigma sample sequencer.
package dsm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } dsm_state_e;

  // Mid-scale code of an unsigned offset-binary word of the given width.
  function automatic int unsigned dsm_midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dsm_sample_fifo.sv
// Small sample FIFO with registered occupancy, head peek and synchronous flush.
module dsm_sample_fifo
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // A pop on an empty FIFO is ignored, so a same-cycle push is never bypassed.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/dsm_sample_sequencer.sv
// Sample scheduler and pop-free start/stop ramp controller feeding dsm_module.data_i.
module dsm_sample_sequencer
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RAMP_STEP  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] dsm_data_o,
  output logic                  sample_stb_o,
  output logic                  underrun_o,
  output logic [1:0]            state_o
);

  localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(dsm_midscale(DATA_WIDTH));
  localparam int                    CNT_W = $clog2(OSR);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(OSR - 1);

  dsm_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  boundary;
  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] ramp_tgt, ramp_val;

  // Step toward the target without overshoot; the signed difference keeps 0 and full-scale safe.
  function automatic logic [DATA_WIDTH-1:0] step_toward(input logic [DATA_WIDTH-1:0] cur,
                                                        input logic [DATA_WIDTH-1:0] tgt);
    logic signed [DATA_WIDTH:0] diff;
    logic signed [DATA_WIDTH:0] stp;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    stp  = (DATA_WIDTH + 1)'(RAMP_STEP);
    if (diff > stp) begin
      return cur + DATA_WIDTH'(RAMP_STEP);
    end else if (diff < -stp) begin
      return cur - DATA_WIDTH'(RAMP_STEP);
    end else begin
      return tgt;
    end
  endfunction

  dsm_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (s_data_i),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign boundary     = (state_q != IDLE) && (cnt_q == CNT_LAST);
  assign s_ready_o    = ~fifo_full & (state_q != RAMP_DOWN);
  assign fifo_push    = s_valid_i & s_ready_o;
  assign dsm_data_o   = data_q;
  assign sample_stb_o = boundary;
  assign underrun_o   = boundary & (state_q == RUN) & fifo_empty;
  assign state_o      = state_q;

  assign ramp_tgt = (state_q == RAMP_DOWN) ? MID : fifo_head;
  assign ramp_val = step_toward(data_q, ramp_tgt);

  always_comb begin
    if (state_q == IDLE)        cnt_d = '0;
    else if (cnt_q == CNT_LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!en_i) begin
          state_d = RAMP_DOWN;
        end else if (boundary && !fifo_empty) begin
          data_d = ramp_val;
          if (ramp_val == fifo_head) begin
            fifo_pop = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = RAMP_DOWN;
        end else if (boundary && !fifo_empty) begin
          data_d   = fifo_head;
          fifo_pop = 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (boundary) begin
          data_d = ramp_val;
          if (ramp_val == MID) begin
            fifo_flush = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= MID;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_dsm_sample_sequencer.sv
// Directed bench for dsm_sample_sequencer at OSR=4, 8-bit samples, 4-entry FIFO, step 16.
module tb_dsm_sample_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RU   = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RD   = 2'd3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] dsm_data_o;
  logic       sample_stb_o;
  logic       underrun_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  dsm_sample_sequencer #(
    .DATA_WIDTH (8),
    .OSR        (4),
    .FIFO_DEPTH (4),
    .RAMP_STEP  (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .dsm_data_o   (dsm_data_o),
    .sample_stb_o (sample_stb_o),
    .underrun_o   (underrun_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         rep;
    logic       en;
    logic       valid;
    logic [7:0] din;
    logic       rdy;
    logic [7:0] dat;
    logic       stb;
    logic       und;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  logic [7:0] up_ff [8] = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'hFF};
  logic [7:0] dn_ff [8] = '{8'hEF, 8'hDF, 8'hCF, 8'hBF, 8'hAF, 8'h9F, 8'h8F, 8'h80};
  logic [7:0] up_00 [8] = '{8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
  logic [7:0] dn_00 [2] = '{8'h10, 8'h20};

  task automatic add(input int rep, input logic en, input logic valid, input logic [7:0] din,
                     input logic rdy, input logic [7:0] dat, input logic stb, input logic und,
                     input logic [1:0] st);
    vec_t v;
    v.rep = rep; v.en = en; v.valid = valid; v.din = din;
    v.rdy = rdy; v.dat = dat; v.stb = stb; v.und = und; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_data"},  32'(dsm_data_o),   32'h80);
    chk({tag, "_stb"},   32'(sample_stb_o), 32'h0);
    chk({tag, "_und"},   32'(underrun_o),   32'h0);
    chk({tag, "_state"}, 32'(state_o),      32'(S_IDLE));
    chk({tag, "_ready"}, 32'(s_ready_o),    32'h1);
  endtask

  // Called at negedge+1; waits for the next boundary and returns the value that follows it.
  task automatic next_val(output logic [7:0] v);
    int n = 0;
    while (!sample_stb_o && n < 16) begin
      @(negedge clk_i); #1;
      n++;
    end
    if (!sample_stb_o) begin
      checks++;
      errors++;
      $display("FAIL boundary_timeout: got no sample_stb_o expected one within 16 cycles");
    end
    @(posedge clk_i);
    @(negedge clk_i); #1;
    v = dsm_data_o;
  endtask

  task automatic push_in_idle(input logic [7:0] d);
    @(negedge clk_i);
    s_valid_i = 1'b1;
    s_data_i  = d;
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;
    en_i      = 1'b1;
    @(negedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  v;
    logic [12:0] got_vec, exp_vec;

    rst_i = 1'b1; en_i = 1'b0; s_valid_i = 1'b0; s_data_i = 8'h00;

    // Ramp up to 0xC0, stream with a full FIFO, underrun, ramp down with en_i ignored, flush.
    add(1, 0, 1, 8'hC0, 1, 8'h80, 0, 0, S_IDLE);
    add(1, 1, 0, 8'h00, 1, 8'h80, 0, 0, S_IDLE);
    add(3, 1, 0, 8'h00, 1, 8'h80, 0, 0, S_RU);  add(1, 1, 0, 8'h00, 1, 8'h80, 1, 0, S_RU);
    add(3, 1, 0, 8'h00, 1, 8'h90, 0, 0, S_RU);  add(1, 1, 0, 8'h00, 1, 8'h90, 1, 0, S_RU);
    add(3, 1, 0, 8'h00, 1, 8'hA0, 0, 0, S_RU);  add(1, 1, 0, 8'h00, 1, 8'hA0, 1, 0, S_RU);
    add(3, 1, 0, 8'h00, 1, 8'hB0, 0, 0, S_RU);  add(1, 1, 0, 8'h00, 1, 8'hB0, 1, 0, S_RU);
    add(3, 1, 0, 8'h00, 1, 8'hC0, 0, 0, S_RUN);
    add(1, 1, 1, 8'h10, 1, 8'hC0, 1, 1, S_RUN);
    add(1, 1, 1, 8'h20, 1, 8'hC0, 0, 0, S_RUN);
    add(1, 1, 1, 8'h30, 1, 8'hC0, 0, 0, S_RUN);
    add(1, 1, 1, 8'h40, 1, 8'hC0, 0, 0, S_RUN);
    add(1, 1, 1, 8'h50, 0, 8'hC0, 1, 0, S_RUN);
    add(1, 1, 1, 8'h50, 1, 8'h10, 0, 0, S_RUN);
    add(2, 1, 0, 8'h00, 0, 8'h10, 0, 0, S_RUN); add(1, 1, 0, 8'h00, 0, 8'h10, 1, 0, S_RUN);
    add(3, 1, 0, 8'h00, 1, 8'h20, 0, 0, S_RUN); add(1, 1, 0, 8'h00, 1, 8'h20, 1, 0, S_RUN);
    add(3, 1, 0, 8'h00, 1, 8'h30, 0, 0, S_RUN); add(1, 1, 0, 8'h00, 1, 8'h30, 1, 0, S_RUN);
    add(3, 1, 0, 8'h00, 1, 8'h40, 0, 0, S_RUN); add(1, 1, 0, 8'h00, 1, 8'h40, 1, 0, S_RUN);
    add(3, 1, 0, 8'h00, 1, 8'h50, 0, 0, S_RUN); add(1, 1, 0, 8'h00, 1, 8'h50, 1, 1, S_RUN);
    add(3, 1, 0, 8'h00, 1, 8'h50, 0, 0, S_RUN); add(1, 1, 0, 8'h00, 1, 8'h50, 1, 1, S_RUN);
    add(1, 1, 1, 8'h35, 1, 8'h50, 0, 0, S_RUN);
    add(2, 1, 0, 8'h00, 1, 8'h50, 0, 0, S_RUN); add(1, 1, 0, 8'h00, 1, 8'h50, 1, 0, S_RUN);
    add(1, 1, 1, 8'h99, 1, 8'h35, 0, 0, S_RUN);
    add(1, 1, 1, 8'h9A, 1, 8'h35, 0, 0, S_RUN);
    add(1, 0, 0, 8'h00, 1, 8'h35, 0, 0, S_RUN);
    add(1, 1, 1, 8'h77, 0, 8'h35, 1, 0, S_RD);
    add(3, 1, 1, 8'h77, 0, 8'h45, 0, 0, S_RD);  add(1, 1, 1, 8'h77, 0, 8'h45, 1, 0, S_RD);
    add(3, 1, 1, 8'h77, 0, 8'h55, 0, 0, S_RD);  add(1, 1, 1, 8'h77, 0, 8'h55, 1, 0, S_RD);
    add(3, 1, 1, 8'h77, 0, 8'h65, 0, 0, S_RD);  add(1, 1, 1, 8'h77, 0, 8'h65, 1, 0, S_RD);
    add(3, 1, 1, 8'h77, 0, 8'h75, 0, 0, S_RD);  add(1, 1, 1, 8'h77, 0, 8'h75, 1, 0, S_RD);
    add(1, 1, 0, 8'h00, 1, 8'h80, 0, 0, S_IDLE);
    add(3, 1, 0, 8'h00, 1, 8'h80, 0, 0, S_RU);  add(1, 1, 0, 8'h00, 1, 8'h80, 1, 0, S_RU);
    add(1, 0, 0, 8'h00, 1, 8'h80, 0, 0, S_RU);
    add(2, 0, 0, 8'h00, 0, 8'h80, 0, 0, S_RD);  add(1, 0, 0, 8'h00, 0, 8'h80, 1, 0, S_RD);
    add(2, 0, 0, 8'h00, 1, 8'h80, 0, 0, S_IDLE);

    repeat (3) @(negedge clk_i);
    #1;
    chk_reset_values("reset_hold");
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        @(negedge clk_i);
        en_i      = tbl[i].en;
        s_valid_i = tbl[i].valid;
        s_data_i  = tbl[i].din;
        #1;
        got_vec = {s_ready_o, dsm_data_o, sample_stb_o, underrun_o, state_o};
        exp_vec = {tbl[i].rdy, tbl[i].dat, tbl[i].stb, tbl[i].und, tbl[i].st};
        chk($sformatf("vec_row%0d_cyc%0d {rdy,data,stb,und,state}", i, r),
            32'(got_vec), 32'(exp_vec));
      end
    end
    @(negedge clk_i);
    s_valid_i = 1'b0;
    en_i      = 1'b0;
    #1;

    // Full-scale target: no wrap on the way up or down.
    push_in_idle(8'hFF);
    for (int k = 0; k < 8; k++) begin
      next_val(v);
      chk($sformatf("ramp_up_ff_%0d", k), 32'(v), 32'(up_ff[k]));
    end
    chk("ramp_up_ff_state", 32'(state_o), 32'(S_RUN));
    en_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      next_val(v);
      chk($sformatf("ramp_dn_ff_%0d", k), 32'(v), 32'(dn_ff[k]));
    end
    chk("ramp_dn_ff_state", 32'(state_o), 32'(S_IDLE));

    // Zero target, then asynchronous reset in the middle of the ramp down.
    push_in_idle(8'h00);
    for (int k = 0; k < 8; k++) begin
      next_val(v);
      chk($sformatf("ramp_up_00_%0d", k), 32'(v), 32'(up_00[k]));
    end
    chk("ramp_up_00_state", 32'(state_o), 32'(S_RUN));
    en_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next_val(v);
      chk($sformatf("ramp_dn_00_%0d", k), 32'(v), 32'(dn_00[k]));
    end
    chk("pre_reset_state", 32'(state_o), 32'(S_RD));
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_values("reset_async");
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk_reset_values("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
